// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: state encoding and shared constants for the MEM-stage access controller
package mem_access_ctrl_pkg;
  localparam int DW = 16;
  localparam int TIMEOUT_MAX = 15;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-memory request/ack bus between the MEM stage and memory
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;
  logic mem_req;
  logic mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_ack;
  logic [DW-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: counts un-acked request cycles; expired flags the cycle whose count would reach TIMEOUT_MAX
module mem_timeout_cnt
  import mem_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 4'd1;
  assign expired = enable & (cnt == 4'(TIMEOUT_MAX - 1));
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage controller issuing one memory request per load/store and stalling the pipe until ack
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          em_valid,
  input  logic          em_mem_rd,
  input  logic          em_mem_wr,
  input  logic [DW-1:0] em_addr,
  input  logic [DW-1:0] em_wdata,
  mem_access_ctrl_if.master mem,
  output logic          stall,
  output logic [DW-1:0] im_dmem_out,
  output logic          im_kill,
  output logic          im_err
);
  state_t state;
  logic access, expired;
  assign access = em_valid & (em_mem_rd | em_mem_wr);
  mem_timeout_cnt u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state == IDLE),
    .enable((state == REQ) & ~mem.mem_ack),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mem.mem_req <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
      im_dmem_out <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          state <= em_addr[0] ? ERR : REQ;
          mem.mem_req <= ~em_addr[0];
          if (!em_addr[0]) begin
            mem.mem_we <= em_mem_wr & ~em_mem_rd;
            mem.mem_addr <= em_addr;
            mem.mem_wdata <= em_wdata;
          end
        end
        REQ: if (mem.mem_ack) begin
          state <= DONE;
          mem.mem_req <= 1'b0;
          if (!mem.mem_we) im_dmem_out <= mem.mem_rdata;
        end else if (expired) begin
          state <= ERR;
          mem.mem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  // gated by rst_n so a frozen EX/MEM access cannot stall the pipe while held in reset
  assign stall = rst_n & (((state == IDLE) & access) | (state == REQ));
  assign im_kill = stall;
  assign im_err = state == ERR;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed transactions with a cycle-level expectation model checked every cycle
module tb_mem_access_ctrl;
  logic clk = 1'b0, rst_n;
  logic em_valid, em_mem_rd, em_mem_wr;
  logic [15:0] em_addr, em_wdata, im_dmem_out;
  logic stall, im_kill, im_err;
  mem_access_ctrl_if mif();
  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .em_valid(em_valid), .em_mem_rd(em_mem_rd), .em_mem_wr(em_mem_wr),
    .em_addr(em_addr), .em_wdata(em_wdata), .mem(mif), .stall(stall),
    .im_dmem_out(im_dmem_out), .im_kill(im_kill), .im_err(im_err)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int stall_cnt = 0, req_cnt = 0, err_cnt = 0;
  logic chk = 1'b0;
  logic x_stall, x_err, x_req, m_we;
  logic [15:0] m_addr, m_wdata, m_dmem;
  task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk) begin
    cmp("stall", 16'(stall), 16'(x_stall));
    cmp("im_kill", 16'(im_kill), 16'(x_stall));
    cmp("im_err", 16'(im_err), 16'(x_err));
    cmp("mem_req", 16'(mif.mem_req), 16'(x_req));
    cmp("mem_we", 16'(mif.mem_we), 16'(m_we));
    cmp("mem_addr", mif.mem_addr, m_addr);
    cmp("mem_wdata", mif.mem_wdata, m_wdata);
    cmp("im_dmem_out", im_dmem_out, m_dmem);
    stall_cnt += int'(stall);
    req_cnt += int'(mif.mem_req);
    err_cnt += int'(im_err);
  end
  task automatic cyc(input logic s, input logic e, input logic r);
    x_stall = s; x_err = e; x_req = r;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n, input logic stray);
    em_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      mif.mem_ack = stray; mif.mem_rdata = 16'h5555;
      cyc(0, 0, 0);
    end
    mif.mem_ack = 1'b0;
  endtask
  // ack_at = REQ cycle (1-based) carrying the ack; 0 means memory never answers
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input int ack_at, input logic [15:0] rdat);
    logic ackc;
    ackc = 1'b0;
    em_valid = 1'b1; em_mem_rd = rd; em_mem_wr = wr; em_addr = a; em_wdata = wd; mif.mem_ack = 1'b0;
    if (!(rd | wr)) cyc(0, 0, 0);
    else if (a[0]) begin
      cyc(1, 0, 0);
      cyc(0, 1, 0);
    end else begin
      cyc(1, 0, 0);
      m_addr = a; m_wdata = wd; m_we = wr & ~rd;
      for (int n = 1; n <= 15; n++) begin
        ackc = (n == ack_at);
        mif.mem_ack = ackc; mif.mem_rdata = ackc ? rdat : 16'hDEAD;
        cyc(1, 0, 1);
        mif.mem_ack = 1'b0;
        if (ackc) begin
          if (rd) m_dmem = rdat;
          break;
        end
      end
      cyc(0, ~ackc, 0);
    end
    em_valid = 1'b0;
  endtask
  int s0, r0, e0;
  task automatic mark; s0 = stall_cnt; r0 = req_cnt; e0 = err_cnt; endtask
  initial begin
    rst_n = 1'b0; em_valid = 1'b1; em_mem_rd = 1'b1; em_mem_wr = 1'b0; em_addr = 16'h0010; em_wdata = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    x_stall = 0; x_err = 0; x_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_dmem = '0;
    chk = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; em_valid = 1'b0;
    idle(2, 0);
    mark; access(1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF);
    cmp("ld_data", im_dmem_out, 16'hBEEF);
    cmp("ld_stall_cycles", 16'(stall_cnt - s0), 16'd2);
    mark; access(0, 1, 16'h0020, 16'h1234, 5, 16'h9999);
    cmp("st_dmem_kept", im_dmem_out, 16'hBEEF);
    cmp("st_req_cycles", 16'(req_cnt - r0), 16'd5);
    cmp("st_stall_cycles", 16'(stall_cnt - s0), 16'd6);
    mark; access(1, 0, 16'h0011, 16'h0000, 1, 16'h7777);
    cmp("unal_req_cycles", 16'(req_cnt - r0), 16'd0);
    cmp("unal_err_cycles", 16'(err_cnt - e0), 16'd1);
    idle(1, 0);
    mark; access(1, 0, 16'h0030, 16'h0000, 0, 16'h0000);
    cmp("to_req_cycles", 16'(req_cnt - r0), 16'd15);
    cmp("to_err_cycles", 16'(err_cnt - e0), 16'd1);
    mark; access(1, 0, 16'h0040, 16'h0000, 15, 16'hCAFE);
    cmp("ack15_data", im_dmem_out, 16'hCAFE);
    cmp("ack15_err_cycles", 16'(err_cnt - e0), 16'd0);
    access(1, 1, 16'h0050, 16'h7777, 2, 16'h0A0A);
    cmp("rdwr_as_load", im_dmem_out, 16'h0A0A);
    idle(2, 1);
    cmp("stray_ack_data", im_dmem_out, 16'h0A0A);
    em_valid = 1'b0; em_mem_rd = 1'b1; em_addr = 16'h0060; cyc(0, 0, 0);
    mark; access(0, 0, 16'h0060, 16'h0000, 0, 16'h0000);
    access(1, 0, 16'h0062, 16'h0000, 3, 16'h1357);
    cmp("nonmem_then_ld_stall", 16'(stall_cnt - s0), 16'd4);
    em_valid = 1'b1; em_mem_rd = 1'b1; em_mem_wr = 1'b0; em_addr = 16'h0070; em_wdata = 16'h0000;
    cyc(1, 0, 0);
    m_addr = 16'h0070; m_wdata = 16'h0000; m_we = 1'b0;
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    rst_n = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_dmem = '0;
    #1 cmp("rst_req_immediate", 16'(mif.mem_req), 16'd0);
    cyc(0, 0, 0);
    rst_n = 1'b1; em_valid = 1'b0;
    mark; idle(2, 1);
    cmp("post_rst_dmem", im_dmem_out, 16'h0000);
    cmp("post_rst_stray_req", 16'(req_cnt - r0), 16'd0);
    access(1, 0, 16'h0080, 16'h0000, 2, 16'h2468);
    cmp("post_rst_load", im_dmem_out, 16'h2468);
    idle(2, 0);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
